mips_mem_ctrl: RTL and testbench
================================

MIPS_MEM_CTRL -- requirements
Module: mips_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: log2 of word depth; internal array holds 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request accept to response; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1: requester (multicycle datapath/control FSM) presents a request.
REQ-006 SHALL have port req_we, input, 1: 1 = store word, 0 = load/fetch word.
REQ-007 SHALL have port req_addr, input, 32: byte address.
REQ-008 SHALL have port req_wdata, input, 32: store data.
REQ-009 SHALL have port req_ready, output, 1: responder can accept a request this cycle.
REQ-010 SHALL have port rsp_valid, output, 1: one-cycle response pulse.
REQ-011 SHALL have port rsp_rdata, output, 32: load data, valid only while rsp_valid=1.
REQ-012 SHALL have port rsp_err, output, 1: misaligned request, valid only while rsp_valid=1.
REQ-013 SHALL have port busy, output, 1: a request is in flight (state != IDLE).

Function
REQ-014 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; accept occurs on an edge where req_valid=1 and req_ready=1.
REQ-016 SHALL, on accept, capture req_we, req_addr and req_wdata into internal registers and ignore request inputs until the next IDLE.
REQ-017 SHALL, on accept, go to RESP if LATENCY=1, otherwise go to WAIT and load a down-counter with LATENCY-1.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter reaches zero.
REQ-019 SHALL, as a result of REQ-017 and REQ-018, assert rsp_valid in the cycle following the LATENCY-th edge after the accept edge.
REQ-020 SHALL hold rsp_valid high for exactly one cycle (RESP), then return to IDLE; no response backpressure exists.
REQ-021 SHALL index the array with captured addr[ADDR_W+1:2]; higher address bits are ignored (wrap-around aliasing).
REQ-022 SHALL flag misalignment when captured addr[1:0] != 0: rsp_err=1, rsp_rdata=0, and no write is performed.
REQ-023 SHALL, for an aligned store, write the array on the edge entering RESP and return rsp_rdata=0, rsp_err=0.
REQ-024 SHALL, for an aligned load, return the array word as it stands at the RESP cycle; a load issued after a completed store to the same word returns the stored data.
REQ-025 SHALL drive rsp_rdata=0 and rsp_err=0 whenever rsp_valid=0.
REQ-026 SHALL ignore req_valid during WAIT and RESP; the requester holds its request until it is accepted.

Reset
REQ-027 SHALL, while rst=1, immediately force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and busy=0.
REQ-028 SHALL drive req_ready=0 while rst=1, and drive req_ready=1 in the first cycle after rst deasserts.
REQ-029 SHALL abort any in-flight request when rst asserts: no response is issued and no array write occurs.
REQ-030 SHALL NOT reset the array contents.

Verification (LATENCY=2, ADDR_W=8)
REQ-031 SHALL cover: store 0x0000_0010 <- 0xDEADBEEF, then load 0x10 -> two rsp_valid pulses, each 2 edges after its accept; the load returns 0xDEADBEEF with rsp_err=0.
REQ-032 SHALL cover: load 0x0000_0012 -> rsp_err=1 and rsp_rdata=0; a misaligned store to 0x13 leaves word 0x10 unchanged.
REQ-033 SHALL cover: store 0x400 <- 0x1234_5678, then load 0x000 -> 0x1234_5678 (wrap-around aliasing).
REQ-034 SHALL cover: req_valid held high continuously -> req_ready pattern 1,0,0,1 per transaction; exactly one rsp_valid per accept.
REQ-035 SHALL cover: assert rst one cycle after a store accept to 0x20 <- 0xCAFE -> no rsp_valid, and a load of 0x20 after reset does not return 0xCAFE.
REQ-036 SHALL cover: LATENCY=1 rebuild -> rsp_valid in the cycle immediately after the accept edge.

Source files
------------

// File: rtl/mips_mem_ctrl.sv
// Word-addressed memory responder for a multicycle MIPS datapath.
// Accepts one request at a time and answers with a single-cycle pulse LATENCY edges later.
module mips_mem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                we_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                accept;
  logic                aligned;
  logic                src_we;
  logic [ADDR_W+1:0]   src_addr;
  logic [DATA_W-1:0]   src_wdata;
  logic                wr_en;
  logic                unused_addr;

  // Upper address bits alias onto the same words.
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign accept      = req_valid && req_ready;
  assign aligned     = (addr_q[1:0] == 2'b00);

  // With LATENCY=1 the write edge is the accept edge, so take the live request then.
  assign src_we    = (state == IDLE) ? req_we                  : we_q;
  assign src_addr  = (state == IDLE) ? req_addr[ADDR_W+1:0]    : addr_q;
  assign src_wdata = (state == IDLE) ? req_wdata               : wdata_q;
  assign wr_en     = (state_nxt == RESP) && (state != RESP) && src_we &&
                     (src_addr[1:0] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr[ADDR_W+1:0];
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[src_addr[ADDR_W+1:2]] <= src_wdata;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: req_ready = !rst;
      WAIT: busy = 1'b1;
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        rsp_err   = !aligned;
        if (aligned && !we_q) rsp_rdata = mem[addr_q[ADDR_W+1:2]];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_mem_ctrl.sv
// Directed bench for mips_mem_ctrl: LATENCY=2 instance for function, LATENCY=1 instance for timing.
module tb_mips_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a, req_valid_b;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready_a, rsp_valid_a, rsp_err_a, busy_a;
  logic [31:0] rsp_rdata_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, busy_b;
  logic [31:0] rsp_rdata_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_mem_ctrl #(.ADDR_W(8), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .busy(busy_a)
  );

  mips_mem_ctrl #(.ADDR_W(8), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction; sel=0 drives the LATENCY=2 instance, sel=1 the LATENCY=1 one.
  task automatic txn(input bit sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input int exp_lat, input string tag);
    int n;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(sel ? req_ready_b : req_ready_a), 32'd1);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    n = 1;
    while (!(sel ? rsp_valid_b : rsp_valid_a) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"},   32'(n), 32'(exp_lat));
    chk({tag, "_rdata"}, sel ? rsp_rdata_b : rsp_rdata_a, exp_rdata);
    chk({tag, "_err"},   32'(sel ? rsp_err_b : rsp_err_a), 32'(exp_err));
    @(posedge clk); #1;
    chk({tag, "_idle"},  {30'd0, (sel ? rsp_valid_b : rsp_valid_a),
                          (sel ? req_ready_b : req_ready_a)}, 32'd1);
    chk({tag, "_rdz"},   sel ? rsp_rdata_b : rsp_rdata_a, 32'd0);
  endtask

  initial begin
    logic [8:0] rdy_seq, rsp_seq;
    int         pulses;

    rst = 1'b1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready_a), 32'd0);
    chk("rst_busy",  32'(busy_a),      32'd0);
    chk("rst_rsp",   {rsp_rdata_a[30:0], rsp_valid_a}, 32'd0);
    chk("rst_err",   32'(rsp_err_a),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready_a), 32'd1);

    txn(0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, "st10");
    txn(0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, "ld10");
    txn(0, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1, 2, "ld12_mis");
    txn(0, 1'b1, 32'h13,  32'h55555555, 32'h0,        1'b1, 2, "st13_mis");
    txn(0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, "ld10_again");
    txn(0, 1'b1, 32'h400, 32'h12345678, 32'h0,        1'b0, 2, "st400");
    txn(0, 1'b0, 32'h000, 32'h0,        32'h12345678, 1'b0, 2, "ld000_alias");

    // Back-to-back requests with req_valid never dropped.
    @(negedge clk);
    req_we = 1'b0;
    req_addr = 32'h10;
    req_valid_a = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      rdy_seq[k] = req_ready_a;
      rsp_seq[k] = rsp_valid_a;
      @(negedge clk);
    end
    req_valid_a = 1'b0;
    chk("stream_ready", 32'(rdy_seq), 32'(9'b001001001));
    chk("stream_rsp",   32'(rsp_seq), 32'(9'b100100100));

    // Reset one cycle after a store is accepted must abort it.
    txn(0, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 2, "st20_pre");
    @(negedge clk);
    req_we = 1'b1;
    req_addr = 32'h20;
    req_wdata = 32'h0000CAFE;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    chk("abort_busy_before", 32'(busy_a), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy_rst",  32'(busy_a),      32'd0);
    chk("abort_ready_rst", 32'(req_ready_a), 32'd0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_valid_a) pulses++;
      if (k == 1) rst = 1'b0;
    end
    chk("abort_no_rsp", 32'(pulses), 32'd0);
    txn(0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 2, "ld20_after_abort");

    txn(1, 1'b1, 32'h8, 32'hA5A5A5A5, 32'h0,        1'b0, 1, "b_st8");
    txn(1, 1'b0, 32'h8, 32'h0,        32'hA5A5A5A5, 1'b0, 1, "b_ld8");
    txn(1, 1'b0, 32'h9, 32'h0,        32'h0,        1'b1, 1, "b_ld9_mis");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
